core_cache_set: RTL and testbench
=================================

# core_cache_set

One way of the set-associative data cache: a direct-mapped array of 2^cache_entry lines, each holding four 32-bit words (128 bits), a tag, a valid bit and a dirty bit. The 4-way cache controller instantiates four of these, drives one shared index/tag, and uses the per-way hit/modify/miss/valid status to pick hit, fill and write-back actions. Storage is built from `core_cache_sram`, a simple dual-port RAM with registered read.

## Interface
- `cache_entry`, 14, index width; line count = 2^cache_entry; tag width T = 23 - cache_entry.
- `clk`  in  1  single clock, all storage on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `entry`  in  cache_entry  line index (address bits [cache_entry+1:2] of the word address).
- `o_tag`  in  T  tag of the current access, compared against the stored tag.
- `writedata`  in  128  line write data; word i = bits [32i+31:32i].
- `byte_en`  in  4  byte lanes within each enabled word; lane j = bits [8j+7:8j] of the word.
- `write`  in  1  write strobe for the line at `entry`.
- `word_en`  in  4  word enables for a write (1111 on line fill).
- `read_miss`  in  1  qualifies `write`: 1 = fill for a read (line written clean), 0 = store or fill for a write (line written dirty).
- `readdata`  out  128  line data at the index sampled last cycle.
- `wb_addr`  out  23  write-back line address = {stored tag, registered index}.
- `hit`  out  1  valid and stored tag == `o_tag`.
- `modify`  out  1  valid, dirty, and stored tag != `o_tag` (write-back needed).
- `miss`  out  1  !valid, or (stored tag != `o_tag` and !dirty) (line can be replaced without write-back).
- `valid`  out  1  stored valid bit of the indexed line.
- `core_cache_sram` sub-block: parameters `width` (data bits), `widthad` (address bits); positional ports clk, wraddr, wren, wrdata, rdaddr, rddata.

## Operation
- Data: 16 byte-wide `core_cache_sram` instances, or equivalent with per-byte write enables. Tag: one T-bit `core_cache_sram` instance.
- Valid and dirty: 2^cache_entry-bit flop arrays. Both are cleared asynchronously by `rst_n`.
- Write on a rising edge with `write`=1, at index `entry`:
  - Byte (i,j) is written iff word_en[i] & byte_en[j].
  - Tag is set to `o_tag`; valid is set to 1; dirty is set to !read_miss.
- A write never clears valid. There is no invalidate or flush operation.
- Read: every cycle the array reads at `entry`. Stored tag, data, valid, dirty and the index are registered.
- `hit`, `modify`, `miss` are combinational from the registered tag/valid/dirty and the live `o_tag`. The controller holds `o_tag`/`entry` stable across the compare cycle.
- `hit`, `modify` and `miss` are mutually exclusive. When valid=1, exactly one of them is 1.
- `core_cache_sram`:
  - Write: mem[wraddr] <= wrdata when wren.
  - Read: rddata <= mem[rdaddr] every edge.
  - Read-during-write to the same address returns the old data.
  - No reset on the memory contents.

## Timing
- Read latency: 1 cycle. Index N presented before edge k gives `readdata`/`wb_addr`/status for N after edge k.
- Write takes effect at the edge. The same index read at that edge returns pre-write data; the new data appears one cycle later.
- Reset, asserted at any time including mid-write: all valid/dirty bits go to 0 immediately.
  - While valid=0: `valid`=0, `hit`=0, `modify`=0, `miss`=1.
  - `readdata` and `wb_addr` are don't-care until the first edge after reset release. Tag/data contents are not cleared.
- A write while rst_n=0 is ignored.
- Boundary: index 0 and index 2^cache_entry-1 both behave identically to any other index. There is no wrap or aliasing.

## Test plan
- Reset, then read index 0x0000 and 0x3FFF with any tag: valid=0, hit=0, modify=0, miss=1.
- Fill index 0x0123, tag 0x1A5, read_miss=1, word_en=1111, byte_en=1111, data 0x44443333_22221111_00001111_DEADBEEF. Next-cycle read with tag 0x1A5: hit=1, readdata matches, dirty clear. Same read with tag 0x0F0: miss=1, modify=0.
- Store to the filled line (read_miss=0, word_en=0100, byte_en=0010, writedata = 4x 0x0000AB00):
  - Read back: word 2 = 0x2222AB11 (lane 1 replaced), other words unchanged.
  - Compare with tag 0x0F0: modify=1, miss=0, wb_addr = {9'h1A5, 14'h0123}.
- Write and read index 0x0200 at the same edge: readdata is old contents. Next cycle: new contents.
- Assert rst_n low asynchronously mid-sequence: valid, hit and modify drop before the next clock edge; miss=1.
- Refill a dirty line with read_miss=1: dirty cleared, so the next mismatching compare reports miss=1, modify=0.

Source files
------------

// File: rtl/core_cache_set.sv
// One way of the set-associative data cache: byte-lane data RAMs, a tag RAM and
// valid/dirty flop arrays, with registered read and hit/modify/miss status.

module core_cache_sram #(
    parameter int width   = 8,
    parameter int widthad = 14
) (
    input  logic               clk,
    input  logic [widthad-1:0] wraddr,
    input  logic               wren,
    input  logic [width-1:0]   wrdata,
    input  logic [widthad-1:0] rdaddr,
    output logic [width-1:0]   rddata
);

    logic [width-1:0] mem [0:(2**widthad)-1];

    // Memory write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wraddr] <= wrdata;
        end
    end

    // Registered read port; a same-address write at this edge is not visible yet.
    always_ff @(posedge clk) begin
        rddata <= mem[rdaddr];
    end

endmodule

module core_cache_set #(
    parameter int cache_entry = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [cache_entry-1:0]    entry,
    input  logic [22-cache_entry:0]   o_tag,
    input  logic [127:0]              writedata,
    input  logic [3:0]                byte_en,
    input  logic                      write,
    input  logic [3:0]                word_en,
    input  logic                      read_miss,
    output logic [127:0]              readdata,
    output logic [22:0]               wb_addr,
    output logic                      hit,
    output logic                      modify,
    output logic                      miss,
    output logic                      valid
);

    localparam int TAG_W = 23 - cache_entry;
    localparam int LINES = 1 << cache_entry;

    logic [LINES-1:0]       valid_arr_d, valid_arr_q;
    logic [LINES-1:0]       dirty_arr_d, dirty_arr_q;
    logic                   valid_rd_d, valid_rd_q;
    logic                   dirty_rd_d, dirty_rd_q;
    logic [cache_entry-1:0] entry_d, entry_q;
    logic [TAG_W-1:0]       tag_rd_s;
    logic                   wren_s;
    logic                   tag_match_s;

    // Writes presented while reset is held must not disturb tag or data contents.
    assign wren_s = write & rst_n;

    core_cache_sram #(.width(TAG_W), .widthad(cache_entry)) u_tag (
        clk, entry, wren_s, o_tag, entry, tag_rd_s
    );

    for (genvar i = 0; i < 4; i++) begin : g_word
        for (genvar j = 0; j < 4; j++) begin : g_lane
            core_cache_sram #(.width(8), .widthad(cache_entry)) u_byte (
                clk, entry, wren_s & word_en[i] & byte_en[j],
                writedata[32*i+8*j +: 8], entry, readdata[32*i+8*j +: 8]
            );
        end
    end

    // Next-state of the valid/dirty arrays and the registered read of the indexed line.
    always_comb begin
        valid_arr_d = valid_arr_q;
        dirty_arr_d = dirty_arr_q;
        if (wren_s) begin
            valid_arr_d[entry] = 1'b1;
            dirty_arr_d[entry] = ~read_miss;
        end else begin
            valid_arr_d = valid_arr_q;
            dirty_arr_d = dirty_arr_q;
        end
        // Read samples the pre-write state, matching the RAM read-during-write behaviour.
        valid_rd_d = valid_arr_q[entry];
        dirty_rd_d = dirty_arr_q[entry];
        entry_d    = entry;
    end

    // State registers; reset clears status immediately so the compare reports miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_arr_q <= '0;
            dirty_arr_q <= '0;
            valid_rd_q  <= 1'b0;
            dirty_rd_q  <= 1'b0;
            entry_q     <= '0;
        end else begin
            valid_arr_q <= valid_arr_d;
            dirty_arr_q <= dirty_arr_d;
            valid_rd_q  <= valid_rd_d;
            dirty_rd_q  <= dirty_rd_d;
            entry_q     <= entry_d;
        end
    end

    assign wb_addr = {tag_rd_s, entry_q};

    // Status compare against the live tag; exactly one of hit/modify/miss when valid.
    always_comb begin
        tag_match_s = (tag_rd_s == o_tag);
        valid       = valid_rd_q;
        hit         = valid_rd_q & tag_match_s;
        modify      = valid_rd_q & dirty_rd_q & ~tag_match_s;
        miss        = ~valid_rd_q | (~tag_match_s & ~dirty_rd_q);
    end

endmodule

// File: tb/tb_core_cache_set.sv
// Directed self-checking bench for core_cache_set: fill, store, boundary indices,
// read-during-write, dirty refill and asynchronous reset.

module tb_core_cache_set;

    logic         clk;
    logic         rst_n;
    logic [13:0]  entry;
    logic [8:0]   o_tag;
    logic [127:0] writedata;
    logic [3:0]   byte_en;
    logic         write;
    logic [3:0]   word_en;
    logic         read_miss;
    logic [127:0] readdata;
    logic [22:0]  wb_addr;
    logic         hit;
    logic         modify;
    logic         miss;
    logic         valid;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] DATA_FILL  = 128'h44443333_22221111_00001111_DEADBEEF;
    localparam logic [127:0] DATA_STORE = 128'h44443333_2222AB11_00001111_DEADBEEF;
    localparam logic [127:0] DATA_A     = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    localparam logic [127:0] DATA_B     = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    localparam logic [127:0] DATA_C     = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [127:0] DATA_D     = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
    localparam logic [127:0] DATA_E     = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;

    core_cache_set #(.cache_entry(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .entry     (entry),
        .o_tag     (o_tag),
        .writedata (writedata),
        .byte_en   (byte_en),
        .write     (write),
        .word_en   (word_en),
        .read_miss (read_miss),
        .readdata  (readdata),
        .wb_addr   (wb_addr),
        .hit       (hit),
        .modify    (modify),
        .miss      (miss),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Status packed as {valid, hit, modify, miss}.
    function automatic logic [127:0] stat();
        return {124'd0, valid, hit, modify, miss};
    endfunction

    initial begin
        rst_n     = 1'b0;
        entry     = 14'h0000;
        o_tag     = 9'h000;
        writedata = 128'd0;
        byte_en   = 4'b0000;
        write     = 1'b0;
        word_en   = 4'b0000;
        read_miss = 1'b0;

        step();
        step();
        chk("reset_status", stat(), 128'h1);

        rst_n = 1'b1;
        entry = 14'h0000;
        o_tag = 9'h1A5;
        step();
        chk("idx0_empty", stat(), 128'h1);
        entry = 14'h3FFF;
        o_tag = 9'h0F0;
        step();
        chk("idxmax_empty", stat(), 128'h1);

        // Clean fill of index 0x0123.
        entry     = 14'h0123;
        o_tag     = 9'h1A5;
        writedata = DATA_FILL;
        write     = 1'b1;
        read_miss = 1'b1;
        word_en   = 4'b1111;
        byte_en   = 4'b1111;
        step();
        write = 1'b0;
        step();
        chk("fill_data", readdata, DATA_FILL);
        chk("fill_hit", stat(), 128'hC);
        o_tag = 9'h0F0;
        #1;
        chk("fill_clean_miss", stat(), 128'h9);

        // Partial store: word 2, lane 1 only, marks line dirty.
        o_tag     = 9'h1A5;
        writedata = {4{32'h0000AB00}};
        write     = 1'b1;
        read_miss = 1'b0;
        word_en   = 4'b0100;
        byte_en   = 4'b0010;
        step();
        write = 1'b0;
        step();
        chk("store_data", readdata, DATA_STORE);
        chk("store_hit", stat(), 128'hC);
        o_tag = 9'h0F0;
        #1;
        chk("store_modify", stat(), 128'hA);
        chk("store_wb_addr", {105'd0, wb_addr}, {105'd0, 9'h1A5, 14'h0123});

        // Top index written; index 0 must stay untouched.
        entry     = 14'h3FFF;
        o_tag     = 9'h0AA;
        writedata = DATA_D;
        write     = 1'b1;
        read_miss = 1'b0;
        word_en   = 4'b1111;
        byte_en   = 4'b1111;
        step();
        write = 1'b0;
        entry = 14'h0000;
        step();
        chk("idx0_no_alias", stat(), 128'h1);
        entry = 14'h3FFF;
        step();
        chk("idxmax_hit", stat(), 128'hC);
        chk("idxmax_data", readdata, DATA_D);
        chk("idxmax_wb_addr", {105'd0, wb_addr}, {105'd0, 9'h0AA, 14'h3FFF});
        o_tag = 9'h001;
        #1;
        chk("idxmax_modify", stat(), 128'hA);

        // Read-during-write at index 0x0200.
        entry     = 14'h0200;
        o_tag     = 9'h011;
        writedata = DATA_A;
        write     = 1'b1;
        read_miss = 1'b1;
        step();
        writedata = DATA_B;
        step();
        chk("rdw_old_data", readdata, DATA_A);
        write = 1'b0;
        step();
        chk("rdw_new_data", readdata, DATA_B);
        chk("rdw_hit", stat(), 128'hC);

        // Clean refill of the dirty line at 0x0123.
        entry     = 14'h0123;
        o_tag     = 9'h1A5;
        writedata = DATA_C;
        write     = 1'b1;
        read_miss = 1'b1;
        step();
        write = 1'b0;
        step();
        chk("refill_data", readdata, DATA_C);
        o_tag = 9'h0F0;
        #1;
        chk("refill_clean_miss", stat(), 128'h9);
        o_tag = 9'h1A5;
        #1;
        chk("refill_hit", stat(), 128'hC);

        // Asynchronous reset between edges, with a write pending.
        #2;
        rst_n     = 1'b0;
        write     = 1'b1;
        read_miss = 1'b0;
        writedata = DATA_E;
        #1;
        chk("async_rst_status", stat(), 128'h1);
        step();
        chk("rst_hold_status", stat(), 128'h1);
        write = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_invalid", stat(), 128'h1);
        chk("post_rst_data_kept", readdata, DATA_C);
        entry = 14'h0200;
        o_tag = 9'h011;
        step();
        chk("post_rst_other_idx", stat(), 128'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
